// File: rtl/sample_history_buffer_if.sv
// Write, read and status signals of the per-channel sample history buffer.
// The master side issues writes, reads and clears; the slave side is the buffer.
interface sample_history_buffer_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int NCH    = 2
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int FW = AW + 1;

    logic                  clear;
    logic [NCH-1:0]        wr_en;
    logic [NCH*DATA_W-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_req;
    logic [CW-1:0]         rd_ch;
    logic [AW-1:0]         rd_offset;
    logic                  rd_valid;
    logic [DATA_W-1:0]     rd_data;
    logic [NCH*FW-1:0]     fill;
    logic                  busy;

    modport master (
        output clear, wr_en, wr_data, rd_req, rd_ch, rd_offset,
        input  wr_ready, rd_valid, rd_data, fill, busy
    );

    modport slave (
        input  clear, wr_en, wr_data, rd_req, rd_ch, rd_offset,
        output wr_ready, rd_valid, rd_data, fill, busy
    );
endinterface

// File: rtl/sample_history_buffer.sv
// Per-channel circular history of recent samples, read back by age (0 = newest).
// A clear pulse empties every channel and sweeps the storage to zero over DEPTH cycles.
//
//   state       | meaning
//   ST_IDLE     | writes accepted, reads answered from history
//   ST_CLEARING | zeroing one address per cycle across all channels; writes dropped
module sample_history_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int NCH    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    sample_history_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int FW = AW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sample_history_buffer: DEPTH must be a power of two and >= 4");
    end
    if (NCH < 1) begin : g_bad_nch
        $fatal(1, "sample_history_buffer: NCH must be >= 1");
    end

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     sweep_q, sweep_d;
    logic [AW-1:0]     wp_q   [NCH];
    logic [FW-1:0]     fill_q [NCH];
    logic [DATA_W-1:0] mem    [NCH][DEPTH];

    logic              busy;
    logic              wr_accept;
    logic              rd_ch_ok;
    logic [AW-1:0]     rd_addr;
    logic [FW-1:0]     rd_fill;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_result;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [NCH*FW-1:0] fill_flat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        wr_accept = (state_q == ST_IDLE) && !bus.clear;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear) begin
                    state_d = ST_CLEARING;
                    sweep_d = '0;
                end
            end
            ST_CLEARING: begin
                if (bus.clear) begin
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                    if (sweep_q == AW'(DEPTH - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            for (int c = 0; c < NCH; c++) begin
                wp_q[c]   <= '0;
                fill_q[c] <= '0;
            end
        end else if (wr_accept) begin
            for (int c = 0; c < NCH; c++) begin
                if (bus.wr_en[c]) begin
                    wp_q[c] <= wp_q[c] + 1'b1;
                    if (fill_q[c] != FW'(DEPTH)) begin
                        fill_q[c] <= fill_q[c] + 1'b1;
                    end
                end
            end
        end
    end

    // Storage is deliberately left unreset; fill masks whatever is stale.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEARING) begin
                for (int c = 0; c < NCH; c++) begin
                    mem[c][sweep_q] <= '0;
                end
            end else if (wr_accept) begin
                for (int c = 0; c < NCH; c++) begin
                    if (bus.wr_en[c]) begin
                        mem[c][wp_q[c]] <= bus.wr_data[c*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Address from the pre-edge pointer gives read-before-write on collision.
    always_comb begin
        rd_ch_ok = 1'b0;
        rd_addr  = '0;
        rd_fill  = '0;
        rd_word  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (bus.rd_ch == CW'(c)) begin
                rd_ch_ok = 1'b1;
                rd_fill  = fill_q[c];
                rd_addr  = wp_q[c] - 1'b1 - bus.rd_offset;
                rd_word  = mem[c][rd_addr];
            end
        end
        rd_result = (rd_ch_ok && ({1'b0, bus.rd_offset} < rd_fill)) ? rd_word : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_req;
            if (bus.rd_req) begin
                rd_data_q <= rd_result;
            end
        end
    end

    always_comb begin
        fill_flat = '0;
        for (int c = 0; c < NCH; c++) begin
            fill_flat[c*FW +: FW] = fill_q[c];
        end
    end

    assign busy         = (state_q == ST_CLEARING);
    assign bus.busy     = busy;
    assign bus.wr_ready = !busy;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.fill     = fill_flat;
endmodule

// File: tb/tb_sample_history_buffer.sv
// Checks the history buffer against a queue-per-channel model every cycle,
// plus directed scenarios with literal expectations.
module tb_sample_history_buffer;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int NCH    = 2;
    localparam int FW     = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sample_history_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NCH(NCH)) bus ();
    sample_history_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NCH(1))   bus1 ();

    sample_history_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NCH(NCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sample_history_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NCH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel is a queue with the newest sample at the front.
    logic [DATA_W-1:0] hist [NCH][$];
    int                clear_left = 0;
    bit                model_ok   = 1'b0;
    bit                exp_valid  = 1'b0;
    logic [DATA_W-1:0] exp_data   = '0;

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) hist[c].delete();
            clear_left = 0;
            exp_valid  = 1'b0;
            exp_data   = '0;
            model_ok   = 1'b1;
        end else if (model_ok) begin
            exp_valid = bus.rd_req;
            if (bus.rd_req) begin
                exp_data = '0;
                if (int'(bus.rd_ch) < NCH && int'(bus.rd_offset) < hist[bus.rd_ch].size())
                    exp_data = hist[bus.rd_ch][bus.rd_offset];
            end
            if (bus.clear) begin
                for (int c = 0; c < NCH; c++) hist[c].delete();
                clear_left = DEPTH;
            end else if (clear_left > 0) begin
                clear_left--;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (bus.wr_en[c]) begin
                        hist[c].push_front(bus.wr_data[c*DATA_W +: DATA_W]);
                        if (hist[c].size() > DEPTH) void'(hist[c].pop_back());
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("busy", {31'b0, bus.busy}, {31'b0, clear_left > 0});
            chk("wr_ready", {31'b0, bus.wr_ready}, {31'b0, clear_left == 0});
            chk("rd_valid", {31'b0, bus.rd_valid}, {31'b0, exp_valid});
            if (exp_valid) chk("rd_data", {16'b0, bus.rd_data}, {16'b0, exp_data});
            for (int c = 0; c < NCH; c++)
                chk("fill", {28'b0, bus.fill[c*FW +: FW]}, hist[c].size());
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.clear = 1'b0; bus.wr_en = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_ch = '0; bus.rd_offset = '0;
        bus1.clear = 1'b0; bus1.wr_en = '0; bus1.wr_data = '0;
        bus1.rd_req = 1'b0; bus1.rd_ch = '0; bus1.rd_offset = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input int c, input logic [DATA_W-1:0] v);
        bus.wr_en[c] = 1'b1;
        bus.wr_data[c*DATA_W +: DATA_W] = v;
        tick();
        bus.wr_en = '0;
    endtask

    task automatic rd(input int c, input int k, output logic [DATA_W-1:0] d);
        bus.rd_req    = 1'b1;
        bus.rd_ch     = 1'(c);
        bus.rd_offset = 3'(k);
        tick();
        chk("rd_valid_lit", {31'b0, bus.rd_valid}, 32'd1);
        d = bus.rd_data;
        bus.rd_req = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int n;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_wr_ready", {31'b0, bus.wr_ready}, 32'd1);
        chk("reset_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        chk("reset_rd_data", {16'b0, bus.rd_data}, 32'd0);
        chk("reset_fill", {24'b0, bus.fill}, 32'd0);

        // wrap-around
        for (int v = 1; v <= 10; v++) wr(0, 16'(v));
        chk("wrap_fill0", {28'b0, bus.fill[3:0]}, 32'd8);
        chk("wrap_fill1", {28'b0, bus.fill[7:4]}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            rd(0, k, d);
            chk("wrap_read", {16'b0, d}, 32'(10 - k));
        end

        // fill masking
        do_reset();
        wr(1, 16'hAAAA);
        rd(1, 0, d); chk("mask_ch1_off0", {16'b0, d}, 32'hAAAA);
        rd(1, 1, d); chk("mask_ch1_off1", {16'b0, d}, 32'h0);
        rd(0, 0, d); chk("mask_ch0_off0", {16'b0, d}, 32'h0);

        // read/write collision
        do_reset();
        for (int v = 1; v <= 8; v++) wr(0, 16'(v));
        bus.wr_en = 2'b01; bus.wr_data[15:0] = 16'd9;
        bus.rd_req = 1'b1; bus.rd_ch = 1'b0; bus.rd_offset = 3'd7;
        tick();
        chk("coll_rd_data", {16'b0, bus.rd_data}, 32'd1);
        idle_inputs();
        rd(0, 0, d); chk("coll_newest", {16'b0, d}, 32'd9);

        // clear sweep
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin
            n++;
            bus.wr_en = 2'b11; bus.wr_data = 32'h7777_7777;
            bus.rd_req = 1'b1; bus.rd_ch = 1'b0; bus.rd_offset = 3'd0;
            tick();
            chk("clear_rd_zero", {16'b0, bus.rd_data}, 32'd0);
        end
        idle_inputs();
        chk("clear_busy_cycles", n, 32'd8);
        chk("clear_fill", {24'b0, bus.fill}, 32'd0);
        wr(0, 16'd5);
        rd(0, 0, d); chk("clear_then_write", {16'b0, d}, 32'd5);

        // reset mid-sweep
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        repeat (3) tick();
        chk("sweep_busy_before_rst", {31'b0, bus.busy}, 32'd1);
        do_reset();
        chk("rst_sweep_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_sweep_wr_ready", {31'b0, bus.wr_ready}, 32'd1);
        wr(0, 16'h1234);
        chk("rst_sweep_fill", {28'b0, bus.fill[3:0]}, 32'd1);
        rd(0, 0, d); chk("rst_sweep_read", {16'b0, d}, 32'h1234);

        // out-of-range channel on the single-channel instance
        bus1.wr_en = 1'b1; bus1.wr_data = 16'h5A5A;
        tick();
        bus1.wr_en = 1'b0;
        bus1.rd_req = 1'b1; bus1.rd_ch = 1'b1; bus1.rd_offset = 3'd0;
        tick();
        chk("oor_rd_valid", {31'b0, bus1.rd_valid}, 32'd1);
        chk("oor_rd_data", {16'b0, bus1.rd_data}, 32'd0);
        bus1.rd_ch = 1'b0;
        tick();
        chk("nch1_ch0_read", {16'b0, bus1.rd_data}, 32'h5A5A);
        bus1.rd_req = 1'b0;

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            bus.clear     = ($urandom_range(0, 39) == 0);
            bus.wr_en     = 2'($urandom);
            bus.wr_data   = $urandom;
            bus.rd_req    = 1'($urandom);
            bus.rd_ch     = 1'($urandom);
            bus.rd_offset = 3'($urandom);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
